// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding, port indices
// and the round-robin selection helper.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // With both slots pending the port that was not served last wins.
  function automatic logic rr_pick(input logic a_pend,
                                   input logic b_pend,
                                   input logic last_port);
    if (a_pend && b_pend) begin
      return !last_port;
    end
    return b_pend ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sram_arbiter_arb_slot.sv
// One requester's pending-request slot: captures a single rd/wr pulse, holds it
// until the arbiter completes it, and flags pulses that had to be dropped.
module arb_slot #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clear,
  output logic                  pending,
  output logic                  is_write,
  output logic [ADDR_WIDTH-1:0] slot_offset,
  output logic [DATA_WIDTH-1:0] slot_data,
  output logic                  overrun
);

  logic                  pending_q, pending_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    accept     = (rd ^ wr) && (!pending_q || clear);
    overrun    = (rd || wr) && !accept;
    pending_d  = pending_q;
    is_write_d = is_write_q;
    offset_d   = offset_q;
    data_d     = data_q;
    if (accept) begin
      pending_d  = 1'b1;
      is_write_d = wr;
      offset_d   = offset;
      data_d     = wdata;
    end else if (clear) begin
      pending_d  = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // NOTE: the payload is deliberately not reset; it is only consumed while
  // pending_q is set, and leaving it reset-free keeps the reset tree small.
  always_ff @(posedge clk) begin
    is_write_q <= is_write_d;
    offset_q   <= offset_d;
    data_q     <= data_d;
  end

  assign pending     = pending_q;
  assign is_write    = is_write_q;
  assign slot_offset = offset_q;
  assign slot_data   = data_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a smart_ram port: round-robin grant,
// one-cycle rd/wr strobe, combinational completion routing and a WAIT timeout.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_rd,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_offset,
  input  logic [DATA_WIDTH-1:0] a_data_out,
  output logic [DATA_WIDTH-1:0] a_data_in,
  output logic                  a_read_finish,
  output logic                  a_write_finish,
  input  logic                  b_rd,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_offset,
  input  logic [DATA_WIDTH-1:0] b_data_out,
  output logic [DATA_WIDTH-1:0] b_data_in,
  output logic                  b_read_finish,
  output logic                  b_write_finish,
  output logic                  sram_rd,
  output logic                  sram_wr,
  output logic [ADDR_WIDTH-1:0] sram_offset,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  input  logic                  sram_read_finish,
  input  logic                  sram_write_finish,
  input  logic                  err_clr,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  busy
);

  localparam int CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT);

  logic                  a_pending, a_is_wr, a_ovr, a_clear;
  logic [ADDR_WIDTH-1:0] a_slot_off;
  logic [DATA_WIDTH-1:0] a_slot_data;
  logic                  b_pending, b_is_wr, b_ovr, b_clear;
  logic [ADDR_WIDTH-1:0] b_slot_off;
  logic [DATA_WIDTH-1:0] b_slot_data;

  arb_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .rd         (a_rd),
    .wr         (a_wr),
    .offset     (a_offset),
    .wdata      (a_data_out),
    .clear      (a_clear),
    .pending    (a_pending),
    .is_write   (a_is_wr),
    .slot_offset(a_slot_off),
    .slot_data  (a_slot_data),
    .overrun    (a_ovr)
  );

  arb_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .rd         (b_rd),
    .wr         (b_wr),
    .offset     (b_offset),
    .wdata      (b_data_out),
    .clear      (b_clear),
    .pending    (b_pending),
    .is_write   (b_is_wr),
    .slot_offset(b_slot_off),
    .slot_data  (b_slot_data),
    .overrun    (b_ovr)
  );

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  op_wr_q, op_wr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sram_rd_q, sram_rd_d;
  logic                  sram_wr_q, sram_wr_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic grant, fin_real, fin_tmo, done;
  logic owner_a, owner_b;

  // A real finish in the timeout cycle counts as a normal completion.
  always_comb begin
    fin_real = (state_q == ST_WAIT) && !rst &&
               (op_wr_q ? sram_write_finish : sram_read_finish);
    fin_tmo  = (state_q == ST_WAIT) && !rst && !fin_real && (cnt_q == CNT_MAX);
    done     = fin_real || fin_tmo;
    owner_a  = (owner_q == PORT_A);
    owner_b  = (owner_q == PORT_B);
    a_clear  = done && owner_a;
    b_clear  = done && owner_b;
  end

  always_comb begin
    a_read_finish  = a_clear && !op_wr_q;
    a_write_finish = a_clear && op_wr_q;
    b_read_finish  = b_clear && !op_wr_q;
    b_write_finish = b_clear && op_wr_q;
    a_data_in      = (fin_real && owner_a && !op_wr_q) ? sram_data_in : '0;
    b_data_in      = (fin_real && owner_b && !op_wr_q) ? sram_data_in : '0;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    op_wr_d   = op_wr_q;
    cnt_d     = cnt_q;
    sram_rd_d = 1'b0;
    sram_wr_d = 1'b0;
    offset_d  = offset_q;
    wdata_d   = wdata_q;
    grant     = rr_pick(a_pending, b_pending, last_q);
    unique case (state_q)
      ST_IDLE: begin
        if (a_pending || b_pending) begin
          state_d   = ST_ISSUE;
          owner_d   = grant;
          op_wr_d   = (grant == PORT_B) ? b_is_wr : a_is_wr;
          offset_d  = (grant == PORT_B) ? b_slot_off : a_slot_off;
          wdata_d   = !op_wr_d ? '0 : ((grant == PORT_B) ? b_slot_data : a_slot_data);
          sram_rd_d = !op_wr_d;
          sram_wr_d = op_wr_d;
          cnt_d     = '0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          state_d  = ST_IDLE;
          last_d   = owner_q;
          offset_d = '0;
          wdata_d  = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overrun_d = (a_ovr || b_ovr) ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    timeout_d = fin_tmo          ? 1'b1 : (err_clr ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_A;
      last_q    <= PORT_B;
      op_wr_q   <= 1'b0;
      cnt_q     <= '0;
      sram_rd_q <= 1'b0;
      sram_wr_q <= 1'b0;
      offset_q  <= '0;
      wdata_q   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      op_wr_q   <= op_wr_d;
      cnt_q     <= cnt_d;
      sram_rd_q <= sram_rd_d;
      sram_wr_q <= sram_wr_d;
      offset_q  <= offset_d;
      wdata_q   <= wdata_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign sram_rd       = sram_rd_q;
  assign sram_wr       = sram_wr_q;
  assign sram_offset   = offset_q;
  assign sram_data_out = wdata_q;
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a scoreboard of expected SRAM accesses
// plus directed completion, timeout, overrun and reset scenarios.
module tb_sram_arbiter;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int TMO = 8;
  localparam logic PA = 1'b0;
  localparam logic PB = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_rd, a_wr, b_rd, b_wr;
  logic [AW-1:0] a_offset, b_offset, sram_offset;
  logic [DW-1:0] a_data_out, b_data_out, a_data_in, b_data_in;
  logic          a_read_finish, a_write_finish, b_read_finish, b_write_finish;
  logic          sram_rd, sram_wr, sram_read_finish, sram_write_finish;
  logic [DW-1:0] sram_data_out, sram_data_in;
  logic          err_clr, overrun, timeout, busy;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_rd             (a_rd),
    .a_wr             (a_wr),
    .a_offset         (a_offset),
    .a_data_out       (a_data_out),
    .a_data_in        (a_data_in),
    .a_read_finish    (a_read_finish),
    .a_write_finish   (a_write_finish),
    .b_rd             (b_rd),
    .b_wr             (b_wr),
    .b_offset         (b_offset),
    .b_data_out       (b_data_out),
    .b_data_in        (b_data_in),
    .b_read_finish    (b_read_finish),
    .b_write_finish   (b_write_finish),
    .sram_rd          (sram_rd),
    .sram_wr          (sram_wr),
    .sram_offset      (sram_offset),
    .sram_data_out    (sram_data_out),
    .sram_data_in     (sram_data_in),
    .sram_read_finish (sram_read_finish),
    .sram_write_finish(sram_write_finish),
    .err_clr          (err_clr),
    .overrun          (overrun),
    .timeout          (timeout),
    .busy             (busy)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] off;
    logic [DW-1:0] data;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each SRAM strobe must match the oldest expected access.
  always @(negedge clk) begin
    if (sram_rd || sram_wr) begin
      check("sram_pulse_width", 32'(prev_pulse), 32'd0);
      check("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_op_wr", 32'(sram_wr), 32'(mon_e.wr));
        check("sb_offset", 32'(sram_offset), 32'(mon_e.off));
        if (mon_e.wr) check("sb_wdata", 32'(sram_data_out), 32'(mon_e.data));
      end
    end
    prev_pulse = sram_rd || sram_wr;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic ar, input logic aw, input logic [AW-1:0] ao,
                       input logic [DW-1:0] ad, input logic br, input logic bw,
                       input logic [AW-1:0] bo, input logic [DW-1:0] bd);
    a_rd = ar; a_wr = aw; a_offset = ao; a_data_out = ad;
    b_rd = br; b_wr = bw; b_offset = bo; b_data_out = bd;
    tick();
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
  endtask

  // Waits (bounded) for the strobe, checks its distance, then steps into WAIT.
  task automatic await_issue(input string tag, input int exp_gap);
    int gap = 0;
    while (!(sram_rd || sram_wr) && gap < 20) begin
      tick();
      gap++;
    end
    check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
    tick();
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic complete(input string tag, input logic wr, input logic port,
                          input logic [AW-1:0] off, input logic [DW-1:0] d);
    logic [3:0] exp_fin;
    exp_fin = (port == PB) ? {2'b00, !wr, wr} : {!wr, wr, 2'b00};
    check({tag, "_off_hold"}, 32'(sram_offset), 32'(off));
    sram_read_finish = !wr; sram_write_finish = wr; sram_data_in = d;
    #1;
    check({tag, "_fin"}, 32'({a_read_finish, a_write_finish, b_read_finish, b_write_finish}),
          32'(exp_fin));
    check({tag, "_a_data"}, 32'(a_data_in), (port == PA && !wr) ? 32'(d) : 32'd0);
    check({tag, "_b_data"}, 32'(b_data_in), (port == PB && !wr) ? 32'(d) : 32'd0);
    tick();
    sram_read_finish = 1'b0; sram_write_finish = 1'b0; sram_data_in = '0;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    a_rd = 1'b0; a_wr = 1'b0; a_offset = '0; a_data_out = '0;
    b_rd = 1'b0; b_wr = 1'b0; b_offset = '0; b_data_out = '0;
    sram_read_finish = 1'b0; sram_write_finish = 1'b0; sram_data_in = '0;
    tick(); tick();
    check("rst_ctrl", 32'({a_read_finish, a_write_finish, b_read_finish, b_write_finish,
                           sram_rd, sram_wr, busy, overrun, timeout}), 32'd0);
    check("rst_bus", 32'({sram_offset, sram_data_out}), 32'd0);
    check("rst_data_in", 32'({a_data_in, b_data_in}), 32'd0);
    rst = 1'b0;
    tick();

    // Collision straight after reset: A first, then B.
    exp_q.push_back('{1'b0, 12'h010, 16'h0000});
    exp_q.push_back('{1'b1, 12'h001, 16'hBEEF});
    pulse(1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b1, 12'h001, 16'hBEEF);
    await_issue("c1_a", 1);
    complete("c1_a", 1'b0, PA, 12'h010, 16'h5555);
    await_issue("c1_b", 1);
    complete("c1_b", 1'b1, PB, 12'h001, 16'h0000);

    // Single read, with a wrong-type finish ignored first.
    exp_q.push_back('{1'b0, 12'h800, 16'h0000});
    pulse(1'b1, 1'b0, 12'h800, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    await_issue("rd", 1);
    sram_write_finish = 1'b1; sram_data_in = 16'h7777;
    #1;
    check("wrong_type_fin", 32'({a_read_finish, a_write_finish, b_read_finish, b_write_finish}), 32'd0);
    tick();
    sram_write_finish = 1'b0; sram_data_in = '0;
    complete("rd", 1'b0, PA, 12'h800, 16'h1234);

    // Finish while IDLE reaches nobody.
    sram_read_finish = 1'b1; sram_data_in = 16'h9999;
    #1;
    check("idle_fin", 32'({a_read_finish, a_write_finish, b_read_finish, b_write_finish}), 32'd0);
    check("idle_data_in", 32'({a_data_in, b_data_in}), 32'd0);
    tick();
    sram_read_finish = 1'b0; sram_data_in = '0;

    // A was served last, so this collision goes to B first.
    exp_q.push_back('{1'b1, 12'h002, 16'hCAFE});
    exp_q.push_back('{1'b0, 12'h020, 16'h0000});
    pulse(1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 1'b1, 12'h002, 16'hCAFE);
    await_issue("c2_b", 1);
    complete("c2_b", 1'b1, PB, 12'h002, 16'h0000);
    await_issue("c2_a", 1);
    complete("c2_a", 1'b0, PA, 12'h020, 16'h0F0F);

    // B posted while A waits is issued two cycles after A's finish.
    exp_q.push_back('{1'b0, 12'h030, 16'h0000});
    pulse(1'b1, 1'b0, 12'h030, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    await_issue("q_a", 1);
    exp_q.push_back('{1'b1, 12'h001, 16'hBEEF});
    pulse(1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b1, 12'h001, 16'hBEEF);
    complete("q_a", 1'b0, PA, 12'h030, 16'hA5A5);
    await_issue("q_b", 1);
    complete("q_b", 1'b1, PB, 12'h001, 16'h0000);

    // Overrun: rd=wr=1, then a second rd while pending.
    pulse(1'b1, 1'b1, 12'h060, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    check("ovr_both", 32'(overrun), 32'd1);
    check("ovr_both_no_access", 32'(busy), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    exp_q.push_back('{1'b0, 12'h040, 16'h0000});
    pulse(1'b1, 1'b0, 12'h040, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    await_issue("ovr", 1);
    pulse(1'b1, 1'b0, 12'h050, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    check("ovr_pending", 32'(overrun), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovr_clr2", 32'(overrun), 32'd0);

    // A pulse in the cycle its own slot completes is accepted.
    exp_q.push_back('{1'b0, 12'h070, 16'h0000});
    a_rd = 1'b1; a_offset = 12'h070;
    complete("ovr_a", 1'b0, PA, 12'h040, 16'h1111);
    a_rd = 1'b0;
    check("same_cycle_no_ovr", 32'(overrun), 32'd0);
    await_issue("acc", 1);
    complete("acc", 1'b0, PA, 12'h070, 16'h2222);

    // Timeout: no finish for TMO WAIT cycles.
    exp_q.push_back('{1'b0, 12'h0AA, 16'h0000});
    pulse(1'b1, 1'b0, 12'h0AA, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    sram_data_in = 16'hDEAD;
    await_issue("tmo", 1);
    for (int i = 0; i < TMO; i++) begin
      check("tmo_early", 32'(a_read_finish), 32'd0);
      tick();
    end
    #1;
    check("tmo_fin", 32'(a_read_finish), 32'd1);
    check("tmo_data", 32'(a_data_in), 32'd0);
    check("tmo_flag_pre", 32'(timeout), 32'd0);
    tick();
    sram_data_in = '0;
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("tmo_clr", 32'(timeout), 32'd0);

    // Reset during a B read, then a late finish.
    exp_q.push_back('{1'b0, 12'h0BB, 16'h0000});
    pulse(1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h0BB, 16'h0);
    await_issue("rstw", 1);
    rst = 1'b1;
    tick();
    sram_read_finish = 1'b1; sram_data_in = 16'h4321;
    #1;
    check("rstw_fin", 32'({a_read_finish, a_write_finish, b_read_finish, b_write_finish}), 32'd0);
    check("rstw_ctrl", 32'({sram_rd, sram_wr, busy, overrun, timeout}), 32'd0);
    check("rstw_bus", 32'({sram_offset, sram_data_out}), 32'd0);
    check("rstw_data_in", 32'({a_data_in, b_data_in}), 32'd0);
    rst = 1'b0;
    tick();
    #1;
    check("post_rst_fin", 32'({a_read_finish, a_write_finish, b_read_finish, b_write_finish}), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    tick();
    sram_read_finish = 1'b0; sram_data_in = '0;
    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample and SRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 12, SRAM offset width.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before an access is aborted.
REQ-004 Ports, in order: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-005 Requester port A (audio path): a_rd in 1; a_wr in 1; a_offset in ADDR_WIDTH; a_data_out in DATA_WIDTH; a_data_in out DATA_WIDTH; a_read_finish out 1; a_write_finish out 1.
REQ-006 Requester port B (effects chain): b_rd, b_wr, b_offset, b_data_out, b_data_in, b_read_finish, b_write_finish, with the same directions and widths as port A.
REQ-007 smart_ram side: sram_rd out 1; sram_wr out 1; sram_offset out ADDR_WIDTH; sram_data_out out DATA_WIDTH; sram_data_in in DATA_WIDTH; sram_read_finish in 1; sram_write_finish in 1.
REQ-008 Status: err_clr in 1 clears the sticky flags; overrun out 1 sticky; timeout out 1 sticky; busy out 1, high whenever state is not IDLE.

Function
REQ-009 Requester rd/wr inputs are one-cycle pulses; on each pulse the arbiter captures the operation type, offset and write data into that port's pending slot at the same clock edge.
REQ-010 A pulse with rd=wr=1, or a pulse arriving while that port's slot is already pending, is dropped and sets overrun.
REQ-011 State machine: IDLE -> ISSUE when any slot is pending; ISSUE -> WAIT unconditionally after one cycle; WAIT -> IDLE on completion or on timeout.
REQ-012 On leaving IDLE, the arbiter selects the owner round-robin: the port other than the last-granted port wins when both slots are pending; after reset, port A has priority.
REQ-013 A request captured at edge k while the arbiter is IDLE with no other pending slot produces the sram_rd or sram_wr pulse in cycle k+1 to k+2 (ISSUE state), exactly one cycle wide.
REQ-014 sram_offset and sram_data_out are registered from the owner's slot and are held stable from ISSUE through WAIT; otherwise they are 0.
REQ-015 In WAIT, the matching finish input (sram_read_finish for a read, sram_write_finish for a write) is routed combinationally to the owner's finish output in the same cycle; sram_data_in is routed to the owner's data_in on a read.
REQ-016 Finish pulses arriving outside WAIT, or of the wrong type, are ignored and never reach either requester.
REQ-017 The non-owner's finish outputs are always 0; both data_in outputs are 0 when not being driven by a completion.
REQ-018 Completion clears the owner's slot and updates last-granted; the next ISSUE occurs no earlier than 2 cycles after the finish cycle.
REQ-019 The WAIT cycle counter is DATA width-independent, sized to hold TIMEOUT; when it reaches TIMEOUT, the arbiter pulses the owner's matching finish output with data_in=0, sets timeout, clears the slot and returns to IDLE.
REQ-020 The non-owner may post a request during ISSUE or WAIT; the request is latched and served next.
REQ-021 A requester pulse in the same cycle that its own slot completes is accepted, not treated as overrun.
REQ-022 err_clr clears overrun and timeout; if a set condition occurs in the same cycle, the set wins.

Reset
REQ-023 While rst is high at a clock edge: state=IDLE, both slots empty, last-granted=B, counter=0, all outputs 0.
REQ-024 Reset during ISSUE or WAIT abandons the access without any finish pulse to the requester; late SRAM finish pulses are then ignored per REQ-016.

Structure
REQ-025 State encodings (IDLE, ISSUE, WAIT) and the port index constants belong in the shared effects package.
REQ-026 One sub-module, arb_slot, holds one port's pending request (capture, clear, overrun detect) and is instantiated twice.

Verification
REQ-027 Single read: a_rd pulse, offset 0x800 -> one-cycle sram_rd with offset 0x800; sram_read_finish with data 0x1234 -> a_read_finish=1, a_data_in=0x1234 in the same cycle; b outputs 0.
REQ-028 Simultaneous requests: a_rd (0x010) and b_wr (0x001, data 0xBEEF) in the same cycle after reset -> A is served first, then B; the next A+B collision serves B first.
REQ-029 Queued: b_wr posted while A is in WAIT -> sram_wr for B is issued 2 cycles after A's finish, with sram_data_out=0xBEEF.
REQ-030 Timeout with TIMEOUT=8: a_rd issued with no finish -> after 8 WAIT cycles, a_read_finish=1, a_data_in=0, timeout=1; err_clr -> timeout=0.
REQ-031 Overrun: a second a_rd while A is pending, and an a_rd=a_wr=1 pulse -> both dropped, overrun=1, exactly one SRAM access.
REQ-032 Reset mid-WAIT: rst during a B read, then sram_read_finish -> no b_read_finish, state IDLE, all outputs 0.
